// File: rtl/transform_ctrl_pkg.sv
// Shared definitions for the two-pass 8x8 transform controller: FSM states,
// operand-mux select codes and the counter terminal value.
package transform_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_P1_ADDR = 3'd1,
        S_P1_WAIT = 3'd2,
        S_P1_WR   = 3'd3,
        S_P2_ADDR = 3'd4,
        S_P2_WAIT = 3'd5,
        S_P2_WR   = 3'd6,
        S_DONE    = 3'd7
    } state_t;

    // Smux1 codes: where the left-hand operand comes from.
    localparam logic SEL_MEM  = 1'b0;
    localparam logic SEL_TEMP = 1'b1;

    // Smux2 codes: which coefficient ROM feeds the multiplier.
    localparam logic SEL_C  = 1'b0;
    localparam logic SEL_CP = 1'b1;

    // Last row/column index of the 8x8 block.
    localparam logic [2:0] DIM_LAST = 3'd7;

    // True on the final element of a pass; the counters wrap to (0,0) after it.
    function automatic logic is_pass_end(input logic [2:0] i, input logic [2:0] j);
        return (i == DIM_LAST) && (j == DIM_LAST);
    endfunction

endpackage

// File: rtl/transform_ctrl_lat_wait.sv
// Read-latency wait counter. Loaded with READ_LAT-1 while the FSM is in an
// ADDR state and counted down in WAIT; last_wait tells the FSM that the
// current WAIT cycle is the final one, so the operand is valid next cycle.
module transform_ctrl_lat_wait #(
    parameter int READ_LAT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic dec,
    output logic last_wait
);

    localparam logic [1:0] LOAD_VAL = 2'(READ_LAT - 1);

    logic [1:0] cnt;

    // Down-counter: reload on ADDR, decrement through WAIT, hold at zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: sequential state always uses non-blocking assignment so every
            // register samples pre-edge values regardless of block ordering.
            cnt <= '0;
        end else if (load) begin
            cnt <= LOAD_VAL;
        end else if (dec && (cnt != 2'd0)) begin
            cnt <= cnt - 2'd1;
        end
    end

    // A count of one means this WAIT cycle brings the counter to zero.
    assign last_wait = (cnt <= 2'd1);

endmodule

// File: rtl/transform_ctrl.sv
// Controller for the two-pass 8x8 separable transform. Pass 1 computes
// T = X*C into the temp RAM, pass 2 streams Y = T*C' out. Each element takes an
// ADDR cycle, READ_LAT-1 WAIT cycles and a WR cycle; counters only advance in WR.
// All outputs are decoded from the registered state (plus the counter readback
// for the row increment), so start never reaches an output combinationally.
module transform_ctrl
    import transform_ctrl_pkg::*;
#(
    parameter int READ_LAT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] out_i,
    input  logic [2:0] out_j,
    output logic       en_i,
    output logic       en_j,
    output logic       Wen_temp,
    output logic       Smux1,
    output logic       Smux2,
    output logic       mem_rd,
    output logic       res_valid,
    output logic       busy,
    output logic       done
);

    state_t state;
    state_t state_next;
    logic   wait_load;
    logic   wait_dec;
    logic   last_wait;
    logic   pass_end;
    logic   row_wrap;

    // With a single-cycle read there is nothing to wait for after ADDR.
    localparam bit SKIP_WAIT = (READ_LAT == 1);

    assign pass_end = is_pass_end(out_i, out_j);
    assign row_wrap = (out_j == DIM_LAST);

    transform_ctrl_lat_wait #(
        .READ_LAT (READ_LAT)
    ) u_lat_wait (
        .clk       (clk),
        .rst       (rst),
        .load      (wait_load),
        .dec       (wait_dec),
        .last_wait (last_wait)
    );

    // State register; asynchronous reset returns to IDLE mid-transform.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and Moore output decode.
    always_comb begin
        // NOTE: every output gets a default before the case, so no path through
        // the block leaves a signal unassigned and no latch is inferred.
        state_next = state;
        wait_load  = 1'b0;
        wait_dec   = 1'b0;
        en_i       = 1'b0;
        en_j       = 1'b0;
        Wen_temp   = 1'b0;
        Smux1      = SEL_MEM;
        Smux2      = SEL_C;
        mem_rd     = 1'b0;
        res_valid  = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (start) state_next = S_P1_ADDR;
            end

            S_P1_ADDR: begin
                busy       = 1'b1;
                mem_rd     = 1'b1;
                wait_load  = 1'b1;
                state_next = SKIP_WAIT ? S_P1_WR : S_P1_WAIT;
            end

            S_P1_WAIT: begin
                busy     = 1'b1;
                wait_dec = 1'b1;
                if (last_wait) state_next = S_P1_WR;
            end

            S_P1_WR: begin
                busy       = 1'b1;
                Wen_temp   = 1'b1;
                en_j       = 1'b1;
                en_i       = row_wrap;
                state_next = pass_end ? S_P2_ADDR : S_P1_ADDR;
            end

            S_P2_ADDR: begin
                busy       = 1'b1;
                Smux1      = SEL_TEMP;
                Smux2      = SEL_CP;
                wait_load  = 1'b1;
                state_next = SKIP_WAIT ? S_P2_WR : S_P2_WAIT;
            end

            S_P2_WAIT: begin
                busy     = 1'b1;
                Smux1    = SEL_TEMP;
                Smux2    = SEL_CP;
                wait_dec = 1'b1;
                if (last_wait) state_next = S_P2_WR;
            end

            S_P2_WR: begin
                busy       = 1'b1;
                Smux1      = SEL_TEMP;
                Smux2      = SEL_CP;
                res_valid  = 1'b1;
                en_j       = 1'b1;
                en_i       = row_wrap;
                state_next = pass_end ? S_DONE : S_P2_ADDR;
            end

            S_DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = S_IDLE;
            end

            default: state_next = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_transform_ctrl.sv
// Bench for transform_ctrl. Two instances (READ_LAT=1 and READ_LAT=3) share
// clock, reset and start. Each has a bench-side 3-bit i/j counter pair standing
// in for the datapath, and a timeline model: cycles since start acceptance map
// arithmetically onto pass / element / slot, from which every output is derived.
module tb_transform_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // ---------------- DUT A: READ_LAT = 1 ----------------
    logic [2:0] i_a, j_a;
    logic en_i_a, en_j_a, wen_a, s1_a, s2_a, rd_a, rv_a, busy_a, done_a;

    transform_ctrl #(.READ_LAT(1)) u_dut_a (
        .clk(clk), .rst(rst), .start(start), .out_i(i_a), .out_j(j_a),
        .en_i(en_i_a), .en_j(en_j_a), .Wen_temp(wen_a), .Smux1(s1_a), .Smux2(s2_a),
        .mem_rd(rd_a), .res_valid(rv_a), .busy(busy_a), .done(done_a)
    );

    // ---------------- DUT B: READ_LAT = 3 ----------------
    logic [2:0] i_b, j_b;
    logic en_i_b, en_j_b, wen_b, s1_b, s2_b, rd_b, rv_b, busy_b, done_b;

    transform_ctrl #(.READ_LAT(3)) u_dut_b (
        .clk(clk), .rst(rst), .start(start), .out_i(i_b), .out_j(j_b),
        .en_i(en_i_b), .en_j(en_j_b), .Wen_temp(wen_b), .Smux1(s1_b), .Smux2(s2_b),
        .mem_rd(rd_b), .res_valid(rv_b), .busy(busy_b), .done(done_b)
    );

    // Datapath counter stand-ins: j increments on en_j, i on en_i, both 3-bit wrap.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            i_a <= '0; j_a <= '0; i_b <= '0; j_b <= '0;
        end else begin
            if (en_j_a) j_a <= j_a + 3'd1;
            if (en_i_a) i_a <= i_a + 3'd1;
            if (en_j_b) j_b <= j_b + 3'd1;
            if (en_i_b) i_b <= i_b + 3'd1;
        end
    end

    // Timeline model: t = 1 in the first cycle after start is accepted,
    // the run lasts 128*(L+1)+1 cycles, and start is only seen while idle.
    localparam int LAT_A = 1;
    localparam int LAT_B = 3;
    bit act_a = 0, act_b = 0;
    int t_a = 0, t_b = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            act_a <= 0; t_a <= 0; act_b <= 0; t_b <= 0;
        end else begin
            if (act_a) begin
                if (t_a == 128 * (LAT_A + 1) + 1) act_a <= 0;
                else t_a <= t_a + 1;
            end else if (start) begin
                act_a <= 1; t_a <= 1;
            end
            if (act_b) begin
                if (t_b == 128 * (LAT_B + 1) + 1) act_b <= 0;
                else t_b <= t_b + 1;
            end else if (start) begin
                act_b <= 1; t_b <= 1;
            end
        end
    end

    // Output order: {en_i, en_j, Wen_temp, Smux1, Smux2, mem_rd, res_valid, busy, done}
    task automatic cmp_dut(input string tag, input int lat, input bit act, input int t,
                           input logic [8:0] got, input logic [2:0] ci, input logic [2:0] cj);
        int per, pass, r, k, o;
        bit wr, adr;
        logic [8:0] exp;
        per = lat + 1;
        exp = '0;
        wr = 0;
        k = 0;
        if (act) begin
            if (t == 128 * per + 1) begin
                exp = 9'b0_0000_0011;
            end else begin
                pass = (t - 1) / (64 * per);
                r    = (t - 1) % (64 * per);
                k    = r / per;
                o    = r % per;
                wr   = (o == per - 1);
                adr  = (o == 0);
                exp[8] = wr && (k % 8 == 7);
                exp[7] = wr;
                exp[6] = wr && (pass == 0);
                exp[5] = (pass == 1);
                exp[4] = (pass == 1);
                exp[3] = adr && (pass == 0);
                exp[2] = wr && (pass == 1);
                exp[1] = 1'b1;
                exp[0] = 1'b0;
            end
        end
        check($sformatf("%s outputs act=%0d t=%0d", tag, act, t), 32'(got), 32'(exp));
        if (wr) check($sformatf("%s write address t=%0d", tag, t), 32'({ci, cj}), 32'(k % 64));
    endtask

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        cmp_dut("A", LAT_A, act_a, t_a,
                {en_i_a, en_j_a, wen_a, s1_a, s2_a, rd_a, rv_a, busy_a, done_a}, i_a, j_a);
        cmp_dut("B", LAT_B, act_b, t_b,
                {en_i_b, en_j_b, wen_b, s1_b, s2_b, rd_b, rv_b, busy_b, done_b}, i_b, j_b);
    end

    // Per-run tallies used for hand-computed literal checks.
    int dc_a, dc_b, nd_a, nd_b, nw_a, nr_a, nw_b, nr_b, nm_b;

    task automatic clear_stats();
        dc_a = -1; dc_b = -1; nd_a = 0; nd_b = 0;
        nw_a = 0; nr_a = 0; nw_b = 0; nr_b = 0; nm_b = 0;
    endtask

    task automatic take_stats(input int n);
        if (done_a) begin dc_a = n; nd_a++; end
        if (done_b) begin dc_b = n; nd_b++; end
        if (wen_a && !s1_a) nw_a++;
        if (rv_a && s1_a && s2_a) nr_a++;
        if (wen_b && !s1_b) nw_b++;
        if (rv_b && s1_b && s2_b) nr_b++;
        if (rd_b) nm_b++;
    endtask

    // Accept start at edge 0, then sample cycles 1..n_cycles; optionally
    // pulse start at cycles 5, 200 and 257, which must all be ignored.
    task automatic run_transform(input bit noise, input int n_cycles);
        clear_stats();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);          // edge 0
        for (int n = 1; n <= n_cycles; n++) begin
            @(negedge clk);
            take_stats(n);
            start = noise && (n == 5 || n == 200 || n == 257);
        end
        start = 1'b0;
    endtask

    task automatic check_full_run(input string tag);
        check({tag, " A done cycle"}, 32'(dc_a), 32'd257);
        check({tag, " B done cycle"}, 32'(dc_b), 32'd513);
        check({tag, " A done pulses"}, 32'(nd_a), 32'd1);
        check({tag, " B done pulses"}, 32'(nd_b), 32'd1);
        check({tag, " A Wen_temp count"}, 32'(nw_a), 32'd64);
        check({tag, " A res_valid count"}, 32'(nr_a), 32'd64);
        check({tag, " B Wen_temp count"}, 32'(nw_b), 32'd64);
        check({tag, " B res_valid count"}, 32'(nr_b), 32'd64);
        check({tag, " B mem_rd count"}, 32'(nm_b), 32'd64);
        check({tag, " A counters end"}, 32'({i_a, j_a}), 32'd0);
        check({tag, " B counters end"}, 32'({i_b, j_b}), 32'd0);
        check({tag, " A idle after run"}, 32'(busy_a), 32'd0);
        check({tag, " B idle after run"}, 32'(busy_b), 32'd0);
    endtask

    initial begin
        // Reset held with random start: everything must stay quiet.
        rst = 1'b0;
        repeat (8) begin
            @(negedge clk);
            start = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        start = 1'b0;
        check("reset A outputs", 32'({en_i_a, en_j_a, wen_a, s1_a, s2_a, rd_a, rv_a, busy_a, done_a}), 32'd0);
        check("reset B outputs", 32'({en_i_b, en_j_b, wen_b, s1_b, s2_b, rd_b, rv_b, busy_b, done_b}), 32'd0);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        check("post-reset idle A busy", 32'(busy_a), 32'd0);
        check("post-reset idle B busy", 32'(busy_b), 32'd0);

        // Clean full runs at both latencies.
        run_transform(1'b0, 530);
        check_full_run("run1");

        // Stray start pulses mid-run and on the DONE cycle of A.
        run_transform(1'b1, 530);
        check_full_run("noise");

        // Reset in pass 2 of A (cycle 150): immediate IDLE, no done.
        clear_stats();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= 150; n++) begin
            @(negedge clk);
            take_stats(n);
            start = 1'b0;
        end
        check("abort A in pass 2", 32'(s1_a), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("abort A outputs", 32'({en_i_a, en_j_a, wen_a, s1_a, s2_a, rd_a, rv_a, busy_a, done_a}), 32'd0);
        check("abort B outputs", 32'({en_i_b, en_j_b, wen_b, s1_b, s2_b, rd_b, rv_b, busy_b, done_b}), 32'd0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        check("abort A no done", 32'(nd_a), 32'd0);
        check("abort B no done", 32'(nd_b), 32'd0);
        check("abort A idle", 32'(busy_a), 32'd0);

        // Fresh start after the abort must give a complete run.
        run_transform(1'b0, 530);
        check_full_run("rerun");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
